// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The datapath (master) reports stage status; the controller (slave) returns stall/flush/hold controls.
interface pipe_hazard_ctrl_if;
   logic [4:0]  rs1_D;
   logic [4:0]  rs2_D;
   logic        useRs1_D;
   logic        useRs2_D;
   logic        mulOp_D;
   logic [4:0]  rd_E;
   logic        memRead_E;
   logic        branchTaken_M;

   logic        stall_F;
   logic        stall_D;
   logic        flush_D;
   logic        flush_E;
   logic        aluHold_E;
   logic [3:0]  mulCount;
   logic [1:0]  state;
   logic [15:0] stallCnt;

   modport master (
      output rs1_D, rs2_D, useRs1_D, useRs2_D, mulOp_D, rd_E, memRead_E, branchTaken_M,
      input  stall_F, stall_D, flush_D, flush_E, aluHold_E, mulCount, state, stallCnt
   );

   modport slave (
      input  rs1_D, rs2_D, useRs1_D, useRs2_D, mulOp_D, rd_E, memRead_E, branchTaken_M,
      output stall_F, stall_D, flush_D, flush_E, aluHold_E, mulCount, state, stallCnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and a multi-cycle ALU
// occupancy FSM, plus a saturating stall-cycle performance counter.
module pipe_hazard_ctrl #(
   parameter int MUL_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MUL_WAIT = 2'd1
   } state_t;

   localparam logic [3:0]  MUL_INIT = 4'(MUL_LAT - 1);
   localparam logic [15:0] CNT_MAX  = 16'hFFFF;

   state_t      state_q, state_d;
   logic [3:0]  mul_count_q, mul_count_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic stall_f, stall_d, flush_d, flush_e, alu_hold_e;

   // Register 31 is the zero register, so a load targeting it never creates a dependency.
   always_comb begin
      load_use = hz.memRead_E && (hz.rd_E != 5'd31) &&
                 ((hz.useRs1_D && (hz.rs1_D == hz.rd_E)) ||
                  (hz.useRs2_D && (hz.rs2_D == hz.rd_E)));
   end

   always_comb begin
      state_d     = state_q;
      mul_count_d = mul_count_q;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      alu_hold_e  = 1'b0;

      case (state_q)
         RUN: begin
            mul_count_d = 4'd0;
            if (hz.branchTaken_M) begin
               flush_d = 1'b1;
               flush_e = 1'b1;
            end else if (load_use) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end else if (hz.mulOp_D) begin
               state_d     = MUL_WAIT;
               mul_count_d = MUL_INIT;
            end
         end

         // The branch is older than the op in execute, so it wins and squashes it.
         MUL_WAIT: begin
            if (hz.branchTaken_M) begin
               flush_d     = 1'b1;
               flush_e     = 1'b1;
               state_d     = RUN;
               mul_count_d = 4'd0;
            end else begin
               stall_f    = 1'b1;
               stall_d    = 1'b1;
               alu_hold_e = 1'b1;
               if (mul_count_q <= 4'd1) begin
                  state_d     = RUN;
                  mul_count_d = 4'd0;
               end else begin
                  mul_count_d = mul_count_q - 4'd1;
               end
            end
         end

         default: begin
            state_d     = RUN;
            mul_count_d = 4'd0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_d && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         mul_count_q <= 4'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         mul_count_q <= mul_count_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.stall_F   = stall_f;
   assign hz.stall_D   = stall_d;
   assign hz.flush_D   = flush_d;
   assign hz.flush_E   = flush_e;
   assign hz.aluHold_E = alu_hold_e;
   assign hz.mulCount  = mul_count_q;
   assign hz.state     = state_q;
   assign hz.stallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with MUL_LAT = 4.
module tb_pipe_hazard_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [15:0] expStallCnt;

   pipe_hazard_ctrl_if hzIf ();

   pipe_hazard_ctrl #(.MUL_LAT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hzIf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic mul, input logic [4:0] rd,
                                input logic memRd, input logic br);
      hzIf.rs1_D         = rs1;
      hzIf.rs2_D         = rs2;
      hzIf.useRs1_D      = u1;
      hzIf.useRs2_D      = u2;
      hzIf.mulOp_D       = mul;
      hzIf.rd_E          = rd;
      hzIf.memRead_E     = memRd;
      hzIf.branchTaken_M = br;
      #1;
   endtask

   task automatic checkCtrl(input string tag, input logic sF, input logic sD, input logic fD,
                            input logic fE, input logic hold);
      checkOutput({tag, ".stall_F"},   {15'd0, hzIf.stall_F},   {15'd0, sF});
      checkOutput({tag, ".stall_D"},   {15'd0, hzIf.stall_D},   {15'd0, sD});
      checkOutput({tag, ".flush_D"},   {15'd0, hzIf.flush_D},   {15'd0, fD});
      checkOutput({tag, ".flush_E"},   {15'd0, hzIf.flush_E},   {15'd0, fE});
      checkOutput({tag, ".aluHold_E"}, {15'd0, hzIf.aluHold_E}, {15'd0, hold});
   endtask

   task automatic checkRegs(input string tag, input logic [1:0] st, input logic [3:0] cnt);
      checkOutput({tag, ".state"},    {14'd0, hzIf.state},    {14'd0, st});
      checkOutput({tag, ".mulCount"}, {12'd0, hzIf.mulCount}, {12'd0, cnt});
      checkOutput({tag, ".stallCnt"}, hzIf.stallCnt,          expStallCnt);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      expStallCnt = 16'd0;
      reset       = 1'b0;
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #12;
      checkRegs("reset", 2'd0, 4'd0);
      checkCtrl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // Load-use on rs1 stalls for exactly one cycle.
      @(negedge clk);
      applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
      checkCtrl("lu_rs1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      stepCycle();
      expStallCnt = 16'd1;
      applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0);
      checkRegs("lu_rs1_after", 2'd0, 4'd0);
      checkCtrl("lu_x31", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0);
      checkCtrl("lu_x31_both", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd7, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
      checkCtrl("lu_rs2_unused", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
      checkCtrl("lu_not_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd7, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
      checkCtrl("lu_rs2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      stepCycle();
      expStallCnt = 16'd2;
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checkRegs("lu_rs2_after", 2'd0, 4'd0);

      // Multi-cycle op occupies execute for four cycles; a load-use mid-op is ignored.
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      checkCtrl("mul_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCycle();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checkRegs("mul_c3", 2'd1, 4'd3);
      checkCtrl("mul_c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      stepCycle();
      expStallCnt = 16'd3;
      applyStimulus(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
      checkRegs("mul_c2", 2'd1, 4'd2);
      checkCtrl("mul_c2_lu", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      stepCycle();
      expStallCnt = 16'd4;
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checkRegs("mul_c1", 2'd1, 4'd1);
      checkCtrl("mul_c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      stepCycle();
      expStallCnt = 16'd5;
      checkRegs("mul_done", 2'd0, 4'd0);
      checkCtrl("mul_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Branch squashes an op in flight at mulCount == 2.
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      stepCycle();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      stepCycle();
      expStallCnt = 16'd6;
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      checkRegs("sq_c2", 2'd1, 4'd2);
      checkCtrl("sq_branch", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checkRegs("sq_after", 2'd0, 4'd0);

      // Branch outranks load-use and a pending op.
      applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1);
      checkCtrl("simul", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checkRegs("simul_after", 2'd0, 4'd0);

      // Load-use outranks a pending op.
      applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
      checkCtrl("lu_over_mul", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      stepCycle();
      expStallCnt = 16'd7;
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checkRegs("lu_over_mul_after", 2'd0, 4'd0);

      // Asynchronous reset in the middle of an op, between clock edges.
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      stepCycle();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      checkRegs("ar_pre", 2'd1, 4'd3);
      #1;
      reset       = 1'b0;
      expStallCnt = 16'd0;
      #1;
      checkRegs("ar_now", 2'd0, 4'd0);
      applyStimulus(5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0);
      checkCtrl("ar_run_rules", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // Continuous load-use drives the counter to saturation.
      repeat (65534) @(posedge clk);
      #1;
      expStallCnt = 16'hFFFE;
      checkRegs("sat_fffe", 2'd0, 4'd0);
      stepCycle();
      expStallCnt = 16'hFFFF;
      checkRegs("sat_ffff", 2'd0, 4'd0);
      stepCycle();
      checkRegs("sat_hold", 2'd0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
